muldiv_unit: RTL

Iterative 32-cycle multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Sits beside the ALU and takes its operands from the register-file read ports (srca / writedata).
- Produces the HI/LO pair plus a one-cycle write strobe that drives the special (HI/LO) register file's write enable and data inputs.
- Its busy output is used by control to stall PC update while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } state_e;

  // op[1] selects divide, op[0] selects unsigned
  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit. Works on operand magnitudes,
// one step per clock for WIDTH clocks, then applies the sign fix-up and
// strobes the HI/LO result out for one cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);
  localparam int CW = $clog2(WIDTH);

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic               r_neg_q;   // negate product / quotient
  logic               r_neg_r;   // negate remainder (dividend sign)
  logic [WIDTH-1:0]   r_a;       // original dividend, returned as hi on divide-by-zero
  logic [WIDTH-1:0]   r_b;       // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0] r_acc;     // {partial hi / remainder, multiplier / quotient}
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dz;

  logic               w_sgn, w_sa, w_sb;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_madd, w_rsh, w_rdiff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_mnext, w_dnext, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic               w_dz;

  // Magnitudes and signs of the incoming operands
  assign w_sgn   = op_is_signed(op_e'(op));
  assign w_sa    = w_sgn & a[WIDTH-1];
  assign w_sb    = w_sgn & b[WIDTH-1];
  assign w_abs_a = w_sa ? -a : a;
  assign w_abs_b = w_sb ? -b : b;

  // Shift-add step: add multiplicand into the top half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
  assign w_mnext = {w_madd, r_acc[WIDTH-1:1]};

  // Restoring divide step: shift in the next dividend bit and keep the
  // difference only when it did not borrow.
  assign w_rsh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_rdiff = w_rsh - {1'b0, r_b};
  assign w_qbit  = ~w_rdiff[WIDTH];
  assign w_dnext = {(w_qbit ? w_rdiff[WIDTH-1:0] : w_rsh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_qbit};

  // Sign fix-up applied at FINISH
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_dz   = r_div & (r_b == '0);

  // Control FSM and datapath registers; reset dominates cancel and start
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= CALC;
            r_cnt   <= '0;
            r_div   <= op_is_div(op_e'(op));
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_a     <= a;
            r_b     <= w_abs_b;
            r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
          end
        end
        CALC: begin
          if (cancel) begin
            r_state <= IDLE;
          end else begin
            r_acc <= r_div ? w_dnext : w_mnext;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH-1)) r_state <= FINISH;
          end
        end
        FINISH: begin
          r_state <= IDLE;
          if (!cancel) begin
            r_done <= 1'b1;
            r_dz   <= w_dz;
            if (w_dz) begin
              r_hi <= r_a;
              r_lo <= '1;
            end else if (r_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              {r_hi, r_lo} <= w_prod;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign dz   = r_dz;
endmodule
